// File: rtl/mem_access_stage.sv
// LEGv8 memory stage: data-memory req/ready/rvalid sequencer, stall and CBZ resolve.
// Optional MEM_ALIGN_CHECK_EN: misaligned (addr[2:0]!=0) ops abort with busErr_M.
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_M,
   input  logic        memRead_M,
   input  logic        memWrite_M,
   input  logic        branch_M,
   input  logic        zero_M,
   input  logic [63:0] aluResult_M,
   input  logic [63:0] writeData_M,
   output logic        PCSrc_M,
   output logic        stall_M,
   output logic [63:0] readData_M,
   output logic        readValid_M,
   output logic        busErr_M,
   output logic        dm_req,
   output logic        dm_we,
   output logic [63:0] dm_addr,
   output logic [63:0] dm_wdata,
   input  logic        dm_ready,
   input  logic        dm_rvalid,
   input  logic [63:0] dm_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [7:0] cnt;
   logic       mem_op;
   logic       expired;

   assign mem_op  = valid_M & (memRead_M | memWrite_M);
   assign expired = (cnt == CNT_MAX);

   assign PCSrc_M = valid_M & branch_M & zero_M;

   // IDLE term is combinational so the op is held from its very first cycle
   assign stall_M = ((state == IDLE) & mem_op)
                  | (state == REQ)
                  | (state == WAIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         dm_req      <= 1'b0;
         dm_we       <= 1'b0;
         dm_addr     <= 64'd0;
         dm_wdata    <= 64'd0;
         readData_M  <= 64'd0;
         readValid_M <= 1'b0;
         busErr_M    <= 1'b0;
      end else begin
         readValid_M <= 1'b0;
         busErr_M    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mem_op) begin
                  dm_addr  <= aluResult_M;
                  dm_wdata <= writeData_M;
                  dm_we    <= memWrite_M;
                  cnt      <= 8'd0;
`ifdef MEM_ALIGN_CHECK_EN
                  if (aluResult_M[2:0] != 3'b000) begin
                     state      <= DONE;
                     busErr_M   <= 1'b1;
                     readData_M <= 64'd0;
                  end else begin
                     state  <= REQ;
                     dm_req <= 1'b1;
                  end
`else
                  state  <= REQ;
                  dm_req <= 1'b1;
`endif
               end
            end
            REQ: begin
               if (dm_ready) begin
                  dm_req <= 1'b0;
                  state  <= dm_we ? DONE : WAIT;
               end else if (expired) begin
                  dm_req     <= 1'b0;
                  state      <= DONE;
                  busErr_M   <= 1'b1;
                  readData_M <= 64'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            WAIT: begin
               if (dm_rvalid) begin
                  readData_M  <= dm_rdata;
                  readValid_M <= 1'b1;
                  state       <= DONE;
               end else if (expired) begin
                  state      <= DONE;
                  busErr_M   <= 1'b1;
                  readData_M <= 64'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the LEGv8 pipelined datapath. Consumes the execute-stage results latched in the EX/MEM register and turns loads/stores into a request/ready/rvalid transaction on the data-memory port. It stalls the pipeline until each transaction completes and returns load data toward MEM/WB. It also resolves conditional branches by combining `branch_M` with the zero flag.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles spent in REQ+WAIT before the access is aborted with `busErr_M`. Legal range 2..255.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `valid_M` input 1: EX/MEM holds a live instruction.
- `memRead_M` input 1: instruction is a load (LDUR).
- `memWrite_M` input 1: instruction is a store (STUR).
- `branch_M` input 1: instruction is CBZ.
- `zero_M` input 1: ALU zero flag from execute.
- `aluResult_M` input 64: effective address.
- `writeData_M` input 64: store data.
- `PCSrc_M` output 1: branch taken, `valid_M & branch_M & zero_M`; combinational.
- `stall_M` output 1: hold IF/ID/EX/MEM registers and PC.
- `readData_M` output 64: load result, registered.
- `readValid_M` output 1: `readData_M` valid this cycle, 1-cycle pulse.
- `busErr_M` output 1: access aborted, 1-cycle pulse.
- `dm_req` output 1: memory request, registered.
- `dm_we` output 1: 1 = write, 0 = read.
- `dm_addr` output 64: request address.
- `dm_wdata` output 64: write data.
- `dm_ready` input 1: memory accepts request this cycle.
- `dm_rvalid` input 1: read data valid.
- `dm_rdata` input 64: read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE.
- IDLE: when `valid_M & (memRead_M | memWrite_M)`, latch `aluResult_M`, `writeData_M` and `memWrite_M` into the address, data and we registers, clear the timeout counter, go to REQ. If `memRead_M` and `memWrite_M` are both high, treat the access as a store.
- REQ: `dm_req`=1 and `dm_addr`/`dm_we`/`dm_wdata` come from the latched registers. These stay stable until `dm_ready`. On `dm_ready`: a store goes to DONE; a load goes to WAIT.
- WAIT: on `dm_rvalid`, capture `dm_rdata` into `readData_M` and go to DONE. `dm_rvalid` in any other state is ignored.
- DONE: `stall_M`=0 so the pipeline advances. `readValid_M`=1 for a completed load only. Next state is IDLE. DONE never re-accepts an operation.
- Stall logic: `stall_M = (IDLE & valid_M & (memRead_M|memWrite_M)) | REQ | WAIT`. The IDLE term is combinational.
- Timeout: the counter increments each cycle in REQ or WAIT. When it reaches `TIMEOUT-1` without completing, go to DONE, pulse `busErr_M`, set `readData_M`=0 and set `readValid_M`=0.
- `PCSrc_M` is independent of the FSM. A branch carries no memory op, so a branch never stalls.

## Timing
- Reset values: `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0, `readData_M`=0, `readValid_M`=0, `busErr_M`=0, `stall_M`=0 with no op present.
- Minimum store latency: 3 cycles (IDLE→REQ→DONE) with `dm_ready` high in the first REQ cycle.
- Minimum load latency: 4 cycles when `dm_rvalid` arrives the cycle after `dm_ready`.
- `dm_rvalid` in the same cycle as `dm_ready` is not sampled; a compliant memory returns data no earlier than the next cycle.
- Reset mid-transaction: the FSM returns to IDLE at that edge and all registered outputs clear. An outstanding `dm_rvalid` arriving later is ignored.
- Back-to-back memory ops: DONE→IDLE inserts one non-stalled cycle, so a following op starts in IDLE on the next instruction.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, an op whose `aluResult_M[2:0]!=0` skips REQ and goes straight to DONE.
  - `busErr_M` pulses and `dm_req` is never asserted.
  - Loads return `readData_M`=0.
- `MEM_ALIGN_CHECK_EN` undefined: no alignment check; the address is forwarded unchanged.

## Test plan
- Store: addr 0x40, data 0xDEADBEEF, `dm_ready` high immediately -> one `dm_req` cycle with `dm_we`=1, addr 0x40, wdata 0xDEADBEEF; `stall_M` high 2 cycles.
- Load with delayed memory: addr 0x80, `dm_ready` after 2 cycles, `dm_rvalid` with 0x1234 3 cycles later -> `readData_M`=0x1234, `readValid_M` one pulse in DONE; `stall_M` low only in DONE.
- Timeout: `TIMEOUT`=4, `dm_ready` held low -> `busErr_M` pulses after 4 REQ cycles, `readValid_M`=0, FSM back to IDLE.
- Reset asserted in WAIT, then `dm_rvalid`=1 -> all outputs 0, no `readValid_M`, `stall_M`=0 with no op.
- CBZ: `branch_M`=1, `zero_M`=1 -> `PCSrc_M`=1 the same cycle, `stall_M`=0. With `zero_M`=0 -> `PCSrc_M`=0.
- With `MEM_ALIGN_CHECK_EN` defined, load at 0x43 -> no `dm_req`, `busErr_M` pulse, `readData_M`=0.
